// File: rtl/mem_io_responder_pkg.sv
// Shared IO window constants and address decode for the memory-side responder.
package mem_io_responder_pkg;

   localparam logic [1:0]  IO_SEL       = 2'b11;
   localparam logic [17:0] IO_TX_ADDR   = 18'h30000;
   localparam logic [17:0] IO_STAT_ADDR = 18'h30004;

   typedef enum logic [1:0] {
      IO_NONE,
      IO_TX,
      IO_STAT
   } io_reg_e;

   function automatic io_reg_e io_decode(input logic [17:0] addr);
      if (addr == IO_TX_ADDR)        return IO_TX;
      else if (addr == IO_STAT_ADDR) return IO_STAT;
      else                           return IO_NONE;
   endfunction

endpackage

// File: rtl/mem_io_responder_fifo.sv
// Byte FIFO for the TX path; head byte is presented combinationally.
module io_byte_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [7:0]               i_data,
   output logic [7:0]               o_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic [$clog2(DEPTH):0]   o_next_count,
   output logic                     o_full,
   output logic                     o_empty
);
   localparam int unsigned PW = $clog2(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_count;
   logic          w_push_ok;
   logic          w_pop_ok;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == (PW+1)'(DEPTH));
   assign w_pop_ok  = i_pop & !o_empty;
   // a full FIFO still accepts a push when the head leaves in the same cycle
   assign w_push_ok = i_push & (!o_full | w_pop_ok);

   assign o_next_count = r_count + (PW+1)'(w_push_ok) - (PW+1)'(w_pop_ok);
   assign o_count      = r_count;
   assign o_data       = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count <= o_next_count;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/mem_io_responder.sv
// Byte-serial RAM model with an IO window: TX FIFO, RX port and halt register.
module mem_io_responder
   import mem_io_responder_pkg::*;
#(
   parameter int unsigned RAM_AW        = 17,
   parameter int unsigned FIFO_DEPTH    = 8,
   parameter string       SIM_INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_pop,
   output logic        halt,
   output logic        overflow
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]        r_ram [2**RAM_AW];
   logic [7:0]        r_mem_din;
   logic              r_io_buffer_full;
   logic              r_halt;
   logic              r_overflow;

   logic              w_io;
   io_reg_e           w_io_reg;
   logic [RAM_AW-1:0] w_ram_addr;
   logic              w_ram_we;
   logic              w_tx_push;
   logic              w_tx_pop;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic [CW-1:0]     w_count;
   logic [CW-1:0]     w_next_count;
   logic              w_unused_addr;

   assign w_io          = (mem_a[17:16] == IO_SEL);
   assign w_io_reg      = io_decode(mem_a[17:0]);
   assign w_ram_addr    = mem_a[RAM_AW-1:0];
   assign w_ram_we      = rdy & mem_wr & !w_io;
   assign w_tx_push     = rdy & mem_wr & (w_io_reg == IO_TX);
   assign w_tx_pop      = tx_valid & tx_ready;
   assign w_unused_addr = ^{mem_a[31:18], w_count};

   io_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_push       (w_tx_push),
      .i_pop        (w_tx_pop),
      .i_data       (mem_dout),
      .o_data       (tx_data),
      .o_count      (w_count),
      .o_next_count (w_next_count),
      .o_full       (w_fifo_full),
      .o_empty      (w_fifo_empty)
   );

   assign tx_valid = !w_fifo_empty;

   always_ff @(posedge clk) begin
      if (w_ram_we) r_ram[w_ram_addr] <= mem_dout;
   end

   // RAM path reads before the write lands, so writes return the old byte
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_din <= '0;
      end else if (rdy) begin
         if (!w_io) begin
            r_mem_din <= r_ram[w_ram_addr];
         end else if (!mem_wr) begin
            case (w_io_reg)
               IO_TX:   r_mem_din <= rx_valid ? rx_data : '0;
               IO_STAT: r_mem_din <= {7'b0, tx_valid};
               default: r_mem_din <= '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_io_buffer_full <= 1'b0;
         r_halt           <= 1'b0;
         r_overflow       <= 1'b0;
      end else begin
         // one slot of slack covers the write issued while the flag is sampled
         r_io_buffer_full <= (w_next_count >= CW'(FIFO_DEPTH - 1));
         if (rdy & mem_wr & (w_io_reg == IO_STAT) & mem_dout[0]) r_halt <= 1'b1;
         if (w_tx_push & w_fifo_full & !w_tx_pop)                  r_overflow <= 1'b1;
      end
   end

   assign rx_pop         = !rst & rdy & !mem_wr & (w_io_reg == IO_TX) & rx_valid;
   assign mem_din        = r_mem_din;
   assign io_buffer_full = r_io_buffer_full;
   assign halt           = r_halt;
   assign overflow       = r_overflow;

endmodule
